// File: rtl/tiny_proc_pkg.sv
// tiny_proc_pkg: shared types and sizing constants for the tiny accumulator core
// and its run-control sequencer.
package tiny_proc_pkg;

  // Instruction memory geometry.
  localparam int unsigned IMEM_SZ = 16;
  localparam int unsigned INST_W  = 8;
  localparam int unsigned PC_W    = $clog2(IMEM_SZ);

  // Number of cycles the core is held in reset before a (re)start.
  localparam int unsigned CLEAR_CYCLES = 2;

  // Last writable imem address; reaching it ends a load.
  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(IMEM_SZ - 1);

  // Sequencer state; encodings are visible on the debug display.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StClear  = 3'd2,
    StRun    = 3'd3,
    StStep   = 3'd4,
    StHalted = 3'd5
  } seq_state_t;

endpackage

// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if: program-load byte handshake plus the imem write port.
// slave  = the sequencer (accepts bytes, drives imem writes)
// master = the host side (offers bytes, observes imem writes)
interface prog_sequencer_if;

  logic                              byte_valid_in;
  logic [tiny_proc_pkg::INST_W-1:0]  byte_in;
  logic                              byte_ready_out;
  logic                              imem_we_out;
  logic [tiny_proc_pkg::PC_W-1:0]    imem_waddr_out;
  logic [tiny_proc_pkg::INST_W-1:0]  imem_wdata_out;

  modport slave (
    input  byte_valid_in,
    input  byte_in,
    output byte_ready_out,
    output imem_we_out,
    output imem_waddr_out,
    output imem_wdata_out
  );

  modport master (
    output byte_valid_in,
    output byte_in,
    input  byte_ready_out,
    input  imem_we_out,
    input  imem_waddr_out,
    input  imem_wdata_out
  );

endinterface

// File: rtl/edge_rise.sv
// edge_rise: registered rising-edge detector. rise_out is high in the cycle where
// d_in is 1 and was 0 at the previous clock edge.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise_out
);

  logic prev_q, prev_d;

  // Previous value always tracks the input, so a held level fires only once.
  always_comb begin
    prev_d   = d_in;
    rise_out = d_in & ~prev_q;
  end

  // Previous-value register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: run-control and program-load controller for the tiny
// accumulator core. Streams bytes into imem, holds the core in reset while
// loading, then runs it free or single-stepped until it reports a frozen PC.
// Optional build macro SEQ_CYCLE_COUNT_EN adds cycle_cnt_out, a saturating
// count of enabled core cycles since the last CLEAR.
module prog_sequencer
  import tiny_proc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req_in,
  input  logic                  run_req_in,
  input  logic                  step_mode_in,
  input  logic                  step_in,
  input  logic                  core_halted_in,
  prog_sequencer_if.slave       bus,
  output logic                  core_rst_out,
  output logic                  core_en_out,
  output logic                  done_out,
  output logic [2:0]            state_out
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]           cycle_cnt_out
`endif
);

  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [1:0]        clr_cnt_q, clr_cnt_d;

  logic              run_rise;
  logic              step_rise;

  logic              byte_ready;
  logic              imem_we;
  logic [INST_W-1:0] imem_wdata;
  logic              core_rst;
  logic              core_en;
  logic              done;

  edge_rise u_run_edge (
    .clk      (clk),
    .rst      (rst),
    .d_in     (run_req_in),
    .rise_out (run_rise)
  );

  edge_rise u_step_edge (
    .clk      (clk),
    .rst      (rst),
    .d_in     (step_in),
    .rise_out (step_rise)
  );

  // Next-state, load-address, clear-counter and output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    clr_cnt_d  = clr_cnt_q;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    imem_wdata = '0;
    core_rst   = 1'b1;
    core_en    = 1'b0;
    done       = 1'b0;

    case (state_q)
      StIdle: begin
        if (load_req_in) begin
          state_d = StLoad;
          addr_d  = '0;
        end else if (run_rise) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end

      StLoad: begin
        if (!load_req_in) begin
          // Abort: earlier writes stay in imem, next load restarts at entry 0.
          // Ready is withheld so no byte is taken on the abort cycle.
          state_d = StIdle;
          addr_d  = '0;
        end else begin
          byte_ready = 1'b1;
          if (bus.byte_valid_in) begin
            imem_we    = 1'b1;
            imem_wdata = bus.byte_in;
            if (addr_q == LAST_ADDR) begin
              addr_d    = '0;
              state_d   = StClear;
              clr_cnt_d = '0;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end
        end
      end

      StClear: begin
        if (clr_cnt_q == 2'(CLEAR_CYCLES - 1)) begin
          state_d = step_mode_in ? StStep : StRun;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      StRun: begin
        core_rst = 1'b0;
        core_en  = 1'b1;
        // Halt wins over a simultaneous switch to single-step.
        if (core_halted_in) begin
          state_d = StHalted;
        end else if (step_mode_in) begin
          state_d = StStep;
        end
      end

      StStep: begin
        core_rst = 1'b0;
        // Only edges seen while already in STEP advance the core; an edge in
        // the transition cycle into STEP is dropped by the detector.
        core_en  = step_rise;
        if (core_halted_in) begin
          state_d = StHalted;
        end else if (!step_mode_in) begin
          state_d = StRun;
        end
      end

      StHalted: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (load_req_in) begin
          state_d = StLoad;
          addr_d  = '0;
        end else if (run_rise) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end

      default: begin
        // Unused encodings recover to IDLE.
        state_d   = StIdle;
        addr_d    = '0;
        clr_cnt_d = '0;
      end
    endcase
  end

  // State, load-address and clear-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign bus.byte_ready_out = byte_ready;
  assign bus.imem_we_out    = imem_we;
  assign bus.imem_waddr_out = addr_q;
  assign bus.imem_wdata_out = imem_wdata;
  assign core_rst_out       = core_rst;
  assign core_en_out        = core_en;
  assign done_out           = done;
  assign state_out          = state_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  // Saturating count of enabled core cycles; restarts on every CLEAR.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == StClear) begin
      cycle_cnt_d = '0;
    end else if (core_en && (cycle_cnt_q != 16'hFFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt_out = cycle_cnt_q;
`endif

endmodule
